// File: rtl/inst_mem_loader.sv
// inst_mem_loader: fills instruction memory from a byte stream and
// holds the CPU in reset until a complete load session has been written.
module inst_mem_loader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MAX_WORDS  = 64,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk_IML,
    input  logic              rst_IML,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t             state;
    logic [6:0]         count;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         byte_idx;
    logic [DATA_W-1:0]  assembled;
    logic [DATA_W-1:0]  asm_next;
    logic               accept;
    logic               legal;
    logic               last_word;

    assign accept    = byte_ready && byte_valid;
    assign legal     = (word_count != 7'd0) && (int'(word_count) <= MAX_WORDS);
    assign last_word = (7'(word_idx) == (count - 7'd1));

    // Shift the incoming byte into the partial word; after four
    // shifts the first byte sits in the lane chosen by BIG_ENDIAN.
    always_comb begin
        asm_next = assembled;
        if (BIG_ENDIAN) begin
            asm_next = {assembled[DATA_W-9:0], byte_in};
        end else begin
            asm_next = {byte_in, assembled[DATA_W-1:8]};
        end
    end

    // Session FSM with all outputs registered.
    always_ff @(posedge clk_IML) begin
        if (rst_IML) begin
            state      <= IDLE;
            count      <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            assembled  <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            state      <= RECV;
                            count      <= word_count;
                            word_idx   <= '0;
                            byte_idx   <= '0;
                            err        <= 1'b0;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        assembled <= asm_next;
                        byte_idx  <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            wr_en      <= 1'b1;
                            wr_addr    <= {word_idx, 2'b00};
                            wr_data    <= asm_next;
                        end
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        word_idx   <= word_idx + 1'b1;
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: table vectors, directed corner sequences and
// randomized sessions checked against a byte-stream reference model.
module tb_inst_mem_loader;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int MAX_WORDS  = 64;
    localparam bit BIG_ENDIAN = 1'b1;

    logic              clk_IML = 1'b0;
    logic              rst_IML;
    logic              start;
    logic [6:0]        word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    inst_mem_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_WORDS (MAX_WORDS),
        .BIG_ENDIAN(BIG_ENDIAN)
    ) dut (
        .clk_IML   (clk_IML),
        .rst_IML   (rst_IML),
        .start     (start),
        .word_count(word_count),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_IML = ~clk_IML;

    int cyc = 0;
    always @(posedge clk_IML) cyc <= cyc + 1;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [6:0] cnt;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    wr_t obs[$];
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  dbl_wr   = 0;
    bit  prev_wr  = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk_IML) begin
        if (wr_en) obs.push_back('{cyc, wr_addr, wr_data});
        if (wr_en && prev_wr) dbl_wr++;
        prev_wr = wr_en;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk_IML);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        if (BIG_ENDIAN)
            return (32'(b0) << 24) | (32'(b1) << 16) | (32'(b2) << 8) | 32'(b3);
        else
            return 32'(b0) | (32'(b1) << 8) | (32'(b2) << 16) | (32'(b3) << 24);
    endfunction

    function automatic bq_t rand_bytes(input int nw);
        bq_t q;
        for (int i = 0; i < nw * 4; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic do_start(input logic [6:0] c);
        start      = 1'b1;
        word_count = c;
        tick();
        start      = 1'b0;
        word_count = 7'($urandom);
    endtask

    task automatic feed_byte(input logic [7:0] b, input bit noise,
                             output int acc, output bit ok);
        int w;
        w          = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (!byte_ready && w < 20) begin
            if (noise) begin
                start      = 1'($urandom);
                word_count = 7'($urandom);
            end
            tick();
            w++;
        end
        start = 1'b0;
        ok    = byte_ready;
        acc   = cyc;
        if (ok) tick();
        byte_valid = 1'b0;
    endtask

    task automatic feed_session(input string tag, input bq_t bytes, input int gap,
                                input bit rnd, input bit noise);
        int   nw;
        int   acc;
        int   w;
        bit   ok;
        int   wc[$];
        logic [31:0] exp;
        nw = bytes.size() / 4;
        obs.delete();
        done_cnt = 0;
        dbl_wr   = 0;
        check({tag, " busy after start"}, 64'(busy), 64'(1));
        check({tag, " hold after start"}, 64'(cpu_hold), 64'(1));
        check({tag, " err after start"}, 64'(err), 64'(0));
        for (int i = 0; i < bytes.size(); i++) begin
            int g;
            g = rnd ? int'($urandom_range(0, 3)) : gap;
            if (i > 0) begin
                repeat (g) begin
                    byte_valid = 1'b0;
                    byte_in    = 8'($urandom);
                    if (noise) begin
                        start      = 1'($urandom);
                        word_count = 7'($urandom);
                    end
                    tick();
                end
                start = 1'b0;
            end
            feed_byte(bytes[i], noise, acc, ok);
            if (!ok) begin
                fail({tag, " byte_ready"});
                return;
            end
            if (i % 4 == 3) wc.push_back(acc);
        end
        w = 0;
        while (!done && w < 12) begin
            tick();
            w++;
        end
        if (!done) begin
            fail({tag, " done pulse"});
            return;
        end
        check({tag, " hold at done"}, 64'(cpu_hold), 64'(1));
        tick();
        check({tag, " done count"}, 64'(done_cnt), 64'(1));
        check({tag, " hold released"}, 64'(cpu_hold), 64'(0));
        check({tag, " busy idle"}, 64'(busy), 64'(0));
        check({tag, " done low"}, 64'(done), 64'(0));
        check({tag, " err kept"}, 64'(err), 64'(0));
        check({tag, " ready idle"}, 64'(byte_ready), 64'(0));
        check({tag, " write count"}, 64'(obs.size()), 64'(nw));
        check({tag, " wr_en width"}, 64'(dbl_wr), 64'(0));
        for (int k = 0; k < nw && k < obs.size(); k++) begin
            exp = pack(bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]);
            check({tag, " addr"}, 64'(obs[k].addr), 64'(k * 4));
            check({tag, " data"}, 64'(obs[k].data), 64'(exp));
            check({tag, " write latency"}, 64'(obs[k].cyc), 64'(wc[k] + 1));
        end
        if (obs.size() > 0)
            check({tag, " done latency"}, 64'(done_cyc), 64'(obs[obs.size()-1].cyc + 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        bq_t  q;
        logic hold0;
        int   nw;

        rst_IML    = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        tick();
        tick();
        check("rst cpu_hold", 64'(cpu_hold), 64'(1));
        check("rst byte_ready", 64'(byte_ready), 64'(0));
        check("rst wr_en", 64'(wr_en), 64'(0));
        check("rst wr_addr", 64'(wr_addr), 64'(0));
        check("rst wr_data", 64'(wr_data), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst err", 64'(err), 64'(0));
        rst_IML = 1'b0;
        tick();

        q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h04};
        do_start(7'd2);
        feed_session("b2b", q, 0, 1'b0, 1'b0);
        check("b2b word0", 64'(obs[0].data), 64'(32'h20010005));
        check("b2b word1", 64'(obs[1].data), 64'(32'hAC020004));

        do_start(7'd2);
        feed_session("gap3", q, 3, 1'b0, 1'b0);
        check("gap3 word1", 64'(obs[1].data), 64'(32'hAC020004));

        tbl[0] = '{7'd0,   1'b1, 1'b0};
        tbl[1] = '{7'd65,  1'b1, 1'b0};
        tbl[2] = '{7'd1,   1'b0, 1'b1};
        tbl[3] = '{7'd127, 1'b1, 1'b0};
        tbl[4] = '{7'd3,   1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            hold0 = cpu_hold;
            obs.delete();
            do_start(tbl[i].cnt);
            check("tbl err", 64'(err), 64'(tbl[i].exp_err));
            check("tbl busy", 64'(busy), 64'(tbl[i].exp_busy));
            if (tbl[i].exp_busy) begin
                feed_session("tbl", rand_bytes(int'(tbl[i].cnt)), 0, 1'b1, 1'b0);
            end else begin
                tick();
                tick();
                check("tbl no write", 64'(obs.size()), 64'(0));
                check("tbl hold kept", 64'(cpu_hold), 64'(hold0));
                check("tbl ready", 64'(byte_ready), 64'(0));
            end
        end

        begin
            int  acc;
            bit  ok;
            q = rand_bytes(3);
            obs.delete();
            do_start(7'd3);
            for (int i = 0; i < 6; i++) feed_byte(q[i], 1'b0, acc, ok);
            rst_IML = 1'b1;
            tick();
            check("mid rst hold", 64'(cpu_hold), 64'(1));
            check("mid rst busy", 64'(busy), 64'(0));
            check("mid rst ready", 64'(byte_ready), 64'(0));
            check("mid rst wr_en", 64'(wr_en), 64'(0));
            rst_IML = 1'b0;
            repeat (8) tick();
            check("mid rst writes", 64'(obs.size()), 64'(1));
            check("mid rst hold idle", 64'(cpu_hold), 64'(1));
            do_start(7'd1);
            feed_session("post rst", rand_bytes(1), 0, 1'b0, 1'b0);
        end

        for (int s = 0; s < 6; s++) begin
            nw = int'($urandom_range(1, 8));
            do_start(7'(nw));
            feed_session("rand", rand_bytes(nw), 0, 1'b1, 1'b1);
        end

        do_start(7'd64);
        feed_session("full", rand_bytes(64), 0, 1'b1, 1'b1);
        check("full last addr", 64'(obs[obs.size()-1].addr), 64'(8'hFC));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
